// File: rtl/dmem_responder_if.sv
// Load/store request and response channels between the core (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
  logic        i_req_vld;
  logic        o_req_rdy;
  logic        i_req_wren;
  logic [31:0] i_req_addr;
  logic [31:0] i_req_wdata;
  logic [3:0]  i_req_bmask;
  logic        o_rsp_vld;
  logic        i_rsp_rdy;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport slave (
    input  i_req_vld, i_req_wren, i_req_addr, i_req_wdata, i_req_bmask, i_rsp_rdy,
    output o_req_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_vld, i_req_wren, i_req_addr, i_req_wdata, i_req_bmask, i_rsp_rdy,
    input  o_req_rdy, o_rsp_vld, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Data-memory / I/O target: one request at a time, byte-masked stores,
// loads answered after READ_WAIT extra cycles, LED registers and synced switches.
module dmem_responder #(
  parameter int          DEPTH_WORDS = 512,
  parameter int          READ_WAIT   = 1,
  parameter logic [31:0] LEDR_ADDR   = 32'h0000_7000,
  parameter logic [31:0] LEDG_ADDR   = 32'h0000_7010,
  parameter logic [31:0] SW_ADDR     = 32'h0000_7800
) (
  input  logic             i_clk,
  input  logic             i_rst,
  dmem_responder_if.slave  bus,
  input  logic [31:0]      i_io_sw,
  output logic [31:0]      o_io_ledr,
  output logic [31:0]      o_io_ledg
);
  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  typedef struct packed {
    logic ram;
    logic ledr;
    logic ledg;
    logic sw;
  } hit_t;

  function automatic hit_t decode(input logic [29:0] w);
    hit_t h;
    h.ram  = ({2'b00, w} < 32'(DEPTH_WORDS));
    h.ledr = (w == LEDR_ADDR[31:2]);
    h.ledg = (w == LEDG_ADDR[31:2]);
    h.sw   = (w == SW_ADDR[31:2]);
    return h;
  endfunction

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              rsp_vld, vld_nxt;
  logic [31:0]       rsp_rdata, rdata_nxt;
  logic              rsp_err, err_nxt;

  logic [3:0][7:0]   mem [DEPTH_WORDS];
  logic [3:0][7:0]   ledr, ledg;
  logic [3:0][7:0]   wbytes;
  logic [31:0]       sw_meta, sw_sync, sw_cap, ld_addr;
  logic [31:0]       sel_addr, ram_rd, sw_val, ld_data;
  logic [AW-1:0]     widx;
  hit_t              hit;
  logic              accept, st_acc, ld_acc, mapped, store_ok;
  logic              unused_addr_bits;

  assign bus.o_req_rdy   = (state == IDLE);
  assign bus.o_rsp_vld   = rsp_vld;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_rsp_err   = rsp_err;
  assign o_io_ledr       = ledr;
  assign o_io_ledg       = ledg;

  assign accept = (state == IDLE) && bus.i_req_vld;
  assign st_acc = accept && bus.i_req_wren;
  assign ld_acc = accept && !bus.i_req_wren;
  assign wbytes = bus.i_req_wdata;

  // In IDLE the live request drives decode so a zero-wait load and a store
  // both see their own address; afterwards the latched load address does.
  assign sel_addr         = (state == IDLE) ? bus.i_req_addr : ld_addr;
  assign sw_val           = (state == IDLE) ? sw_sync : sw_cap;
  assign hit              = decode(sel_addr[31:2]);
  assign widx             = sel_addr[AW+1:2];
  assign ram_rd           = mem[widx];
  assign mapped           = |hit;
  assign store_ok         = hit.ram | hit.ledr | hit.ledg;
  assign unused_addr_bits = ^sel_addr[1:0];

  always_comb begin
    ld_data = '0;
    if (hit.ram)       ld_data = ram_rd;
    else if (hit.ledr) ld_data = ledr;
    else if (hit.ledg) ld_data = ledg;
    else if (hit.sw)   ld_data = sw_val;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_vld   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rsp_vld   <= vld_nxt;
      rsp_rdata <= rdata_nxt;
      rsp_err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    vld_nxt   = rsp_vld;
    rdata_nxt = rsp_rdata;
    err_nxt   = rsp_err;
    case (state)
      IDLE: begin
        vld_nxt   = 1'b0;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
        if (bus.i_req_vld) begin
          if (bus.i_req_wren) begin
            state_nxt = RESP;
            vld_nxt   = 1'b1;
            err_nxt   = !store_ok;
          end else begin
            cnt_nxt = 4'(READ_WAIT);
            if (READ_WAIT == 0) begin
              state_nxt = RESP;
              vld_nxt   = 1'b1;
              rdata_nxt = ld_data;
              err_nxt   = !mapped;
            end else begin
              state_nxt = WAIT;
            end
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_nxt = RESP;
          vld_nxt   = 1'b1;
          rdata_nxt = ld_data;
          err_nxt   = !mapped;
        end
      end
      RESP: begin
        if (bus.i_rsp_rdy) begin
          state_nxt = IDLE;
          vld_nxt   = 1'b0;
          rdata_nxt = '0;
          err_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        vld_nxt   = 1'b0;
        rdata_nxt = '0;
        err_nxt   = 1'b0;
      end
    endcase
  end

  // Switch inputs are asynchronous; two flops before anything samples them.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
      sw_cap  <= '0;
      ld_addr <= '0;
    end else begin
      sw_meta <= i_io_sw;
      sw_sync <= sw_meta;
      if (ld_acc) begin
        sw_cap  <= sw_sync;
        ld_addr <= bus.i_req_addr;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ledr <= '0;
      ledg <= '0;
    end else if (st_acc) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.i_req_bmask[b]) begin
          if (hit.ledr) ledr[b] <= wbytes[b];
          if (hit.ledg) ledg[b] <= wbytes[b];
        end
      end
    end
  end

  // RAM has no reset so contents survive i_rst.
  always_ff @(posedge i_clk) begin
    if (st_acc && hit.ram) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.i_req_bmask[b]) mem[widx][b] <= wbytes[b];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed plus randomized checks of dmem_responder against a word-level
// reference model of RAM, LEDs and switches.
module tb_dmem_responder;
  localparam int          DEPTH   = 512;
  localparam int          RW_MAIN = 1;
  localparam logic [31:0] LEDR_A  = 32'h0000_7000;
  localparam logic [31:0] LEDG_A  = 32'h0000_7010;
  localparam logic [31:0] SW_A    = 32'h0000_7800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] sw  = '0;
  logic [31:0] ledr1, ledg1, ledr0, ledg0, ledr3, ledg3;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder_if bus1 ();
  dmem_responder_if if0 ();
  dmem_responder_if if3 ();

  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_WAIT(RW_MAIN)) dut1 (
    .i_clk(clk), .i_rst(rst), .bus(bus1), .i_io_sw(sw), .o_io_ledr(ledr1), .o_io_ledg(ledg1));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_WAIT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .bus(if0), .i_io_sw(sw), .o_io_ledr(ledr0), .o_io_ledg(ledg0));
  dmem_responder #(.DEPTH_WORDS(DEPTH), .READ_WAIT(3)) dut3 (
    .i_clk(clk), .i_rst(rst), .bus(if3), .i_io_sw(sw), .o_io_ledr(ledr3), .o_io_ledg(ledg3));

  // The two latency-only instances see identical requests.
  logic        lt_vld = 1'b0, lt_wr = 1'b0, lt_rdy = 1'b1;
  logic [31:0] lt_addr = '0, lt_wd = '0;
  logic [3:0]  lt_bm = '0;
  assign if0.i_req_vld = lt_vld;   assign if3.i_req_vld = lt_vld;
  assign if0.i_req_wren = lt_wr;   assign if3.i_req_wren = lt_wr;
  assign if0.i_req_addr = lt_addr; assign if3.i_req_addr = lt_addr;
  assign if0.i_req_wdata = lt_wd;  assign if3.i_req_wdata = lt_wd;
  assign if0.i_req_bmask = lt_bm;  assign if3.i_req_bmask = lt_bm;
  assign if0.i_rsp_rdy = lt_rdy;   assign if3.i_rsp_rdy = lt_rdy;

  // Reference model: what software would see at each address.
  logic [31:0] mem_m [int];
  logic [31:0] ledr_m = '0, ledg_m = '0, sw_m = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] bm);
    logic [31:0] v = old;
    for (int b = 0; b < 4; b++) if (bm[b]) v[b*8 +: 8] = wd[b*8 +: 8];
    return v;
  endfunction

  function automatic void model(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [3:0] bm, output logic [31:0] rd, output logic er);
    int w = int'(a >> 2);
    rd = '0;
    er = 1'b0;
    if (w < DEPTH) begin
      if (wr) mem_m[w] = mrg(mem_m.exists(w) ? mem_m[w] : 32'h0, wd, bm);
      else    rd = mem_m.exists(w) ? mem_m[w] : 32'h0;
    end else if (w == int'(LEDR_A >> 2)) begin
      if (wr) ledr_m = mrg(ledr_m, wd, bm); else rd = ledr_m;
    end else if (w == int'(LEDG_A >> 2)) begin
      if (wr) ledg_m = mrg(ledg_m, wd, bm); else rd = ledg_m;
    end else if (w == int'(SW_A >> 2)) begin
      if (wr) er = 1'b1; else rd = sw_m;
    end else begin
      er = 1'b1;
    end
  endfunction

  // One full transaction on dut1; hold = cycles of response backpressure.
  task automatic xact(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] bm, input int hold, output logic [31:0] rd_out);
    logic [31:0] erd;
    logic        eerr;
    int          lat;
    @(negedge clk);
    chk("req_rdy_idle", 32'(bus1.o_req_rdy), 32'd1);
    bus1.i_req_vld = 1'b1;  bus1.i_req_wren = wr;  bus1.i_req_addr = a;
    bus1.i_req_wdata = wd;  bus1.i_req_bmask = bm; bus1.i_rsp_rdy = (hold == 0);
    @(posedge clk); #1;
    bus1.i_req_vld = 1'b0;
    bus1.i_req_wren = 1'($urandom); bus1.i_req_addr = $urandom;
    bus1.i_req_wdata = $urandom;    bus1.i_req_bmask = 4'($urandom);
    model(wr, a, wd, bm, erd, eerr);
    if (wr) begin
      chk("ledr_after_store", ledr1, ledr_m);
      chk("ledg_after_store", ledg1, ledg_m);
    end
    lat = 1;
    while (!bus1.o_rsp_vld && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk(wr ? "store_latency" : "load_latency", 32'(lat), wr ? 32'd1 : 32'(RW_MAIN + 1));
    chk("rsp_rdata", bus1.o_rsp_rdata, erd);
    chk("rsp_err", 32'(bus1.o_rsp_err), 32'(eerr));
    chk("req_rdy_busy", 32'(bus1.o_req_rdy), 32'd0);
    rd_out = bus1.o_rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_vld", 32'(bus1.o_rsp_vld), 32'd1);
      chk("hold_rdata", bus1.o_rsp_rdata, erd);
      chk("hold_err", 32'(bus1.o_rsp_err), 32'(eerr));
      chk("hold_req_rdy", 32'(bus1.o_req_rdy), 32'd0);
    end
    bus1.i_rsp_rdy = 1'b1;
    @(posedge clk); #1;
    chk("done_vld", 32'(bus1.o_rsp_vld), 32'd0);
    chk("done_req_rdy", 32'(bus1.o_req_rdy), 32'd1);
    chk("done_rdata", bus1.o_rsp_rdata, 32'd0);
    chk("done_err", 32'(bus1.o_rsp_err), 32'd0);
  endtask

  initial begin
    logic [31:0] rd, rd0, rd3, a;
    int          lat0, lat3;
    bus1.i_req_vld = 1'b0; bus1.i_req_wren = 1'b0; bus1.i_req_addr = '0;
    bus1.i_req_wdata = '0; bus1.i_req_bmask = '0;  bus1.i_rsp_rdy = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_rdy", 32'(bus1.o_req_rdy), 32'd1);
    chk("rst_rsp_vld", 32'(bus1.o_rsp_vld), 32'd0);
    chk("rst_rdata", bus1.o_rsp_rdata, 32'd0);
    chk("rst_err", 32'(bus1.o_rsp_err), 32'd0);
    chk("rst_ledr", ledr1, 32'd0);
    chk("rst_ledg", ledg1, 32'd0);
    @(negedge clk) rst = 1'b0;

    xact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 0, rd);
    xact(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd);
    chk("ld_full_word", rd, 32'hDEAD_BEEF);
    xact(1'b1, 32'h10, 32'h0000_00AA, 4'b0001, 0, rd);
    xact(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd);
    chk("ld_byte_merge", rd, 32'hDEAD_BEAA);
    xact(1'b1, 32'h12, 32'h1111_1111, 4'b0000, 0, rd);
    xact(1'b0, 32'h13, 32'h0, 4'b0000, 0, rd);
    chk("ld_bmask0", rd, 32'hDEAD_BEAA);

    xact(1'b1, LEDR_A, 32'h0000_03FF, 4'b1111, 0, rd);
    chk("ledr_3ff", ledr1, 32'h0000_03FF);
    xact(1'b0, LEDR_A, 32'h0, 4'b0000, 0, rd);
    chk("ld_ledr", rd, 32'h0000_03FF);
    xact(1'b1, LEDG_A, 32'h00A5_0000, 4'b0100, 0, rd);
    sw = 32'h55; sw_m = 32'h55;
    repeat (3) @(posedge clk);
    xact(1'b0, SW_A, 32'h0, 4'b0000, 0, rd);
    chk("ld_sw", rd, 32'h55);
    xact(1'b1, SW_A, 32'hFFFF_FFFF, 4'b1111, 0, rd);
    chk("sw_store_ledr", ledr1, 32'h0000_03FF);
    xact(1'b1, 32'h4000, 32'hFFFF_FFFF, 4'b1111, 1, rd);
    xact(1'b0, 32'h4000, 32'h0, 4'b0000, 5, rd);
    chk("ld_unmapped", rd, 32'h0);
    chk("ld_boundary_ram_hi", 32'((DEPTH * 4 - 4) >> 2 < DEPTH), 32'd1);

    // Reset while a load is waiting.
    @(negedge clk);
    bus1.i_req_vld = 1'b1; bus1.i_req_wren = 1'b0; bus1.i_req_addr = 32'h10;
    @(posedge clk); #1;
    bus1.i_req_vld = 1'b0;
    #1 rst = 1'b1;
    #1;
    chk("midrst_vld", 32'(bus1.o_rsp_vld), 32'd0);
    chk("midrst_ledr", ledr1, 32'd0);
    chk("midrst_ledg", ledg1, 32'd0);
    chk("midrst_req_rdy", 32'(bus1.o_req_rdy), 32'd1);
    ledr_m = '0; ledg_m = '0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst_vld", 32'(bus1.o_rsp_vld), 32'd0);
      chk("postrst_req_rdy", 32'(bus1.o_req_rdy), 32'd1);
    end
    xact(1'b0, 32'h10, 32'h0, 4'b0000, 0, rd);
    chk("ram_survives_rst", rd, 32'hDEAD_BEAA);

    // Latency of the READ_WAIT=0 and READ_WAIT=3 builds.
    @(negedge clk);
    lt_vld = 1'b1; lt_wr = 1'b1; lt_addr = 32'h14; lt_wd = 32'h1234_5678; lt_bm = 4'hF;
    @(posedge clk); #1 lt_vld = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lt_vld = 1'b1; lt_wr = 1'b0;
    @(posedge clk); #1 lt_vld = 1'b0;
    lat0 = 0; lat3 = 0; rd0 = '0; rd3 = '0;
    for (int k = 1; k <= 8; k++) begin
      if (if0.o_rsp_vld && lat0 == 0) begin lat0 = k; rd0 = if0.o_rsp_rdata; end
      if (if3.o_rsp_vld && lat3 == 0) begin lat3 = k; rd3 = if3.o_rsp_rdata; end
      @(posedge clk); #1;
    end
    chk("rw0_latency", 32'(lat0), 32'd1);
    chk("rw3_latency", 32'(lat3), 32'd4);
    chk("rw0_rdata", rd0, 32'h1234_5678);
    chk("rw3_rdata", rd3, 32'h1234_5678);

    // Randomized traffic against the model; preload every RAM word it touches.
    for (int w = 0; w < 16; w++) xact(1'b1, 32'(w * 4), $urandom, 4'hF, 0, rd);
    xact(1'b1, 32'((DEPTH - 1) * 4), $urandom, 4'hF, 0, rd);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        sw = $urandom; sw_m = sw;
        repeat (3) @(posedge clk);
      end
      case ($urandom_range(0, 9))
        0, 1, 2, 3: a = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        4:          a = 32'((DEPTH - 1) * 4 + $urandom_range(0, 3));
        5:          a = LEDR_A + 32'($urandom_range(0, 3));
        6:          a = LEDG_A + 32'($urandom_range(0, 3));
        7:          a = SW_A + 32'($urandom_range(0, 3));
        8:          a = 32'(DEPTH * 4 + $urandom_range(0, 3));
        default:    a = LEDR_A + 32'd4;
      endcase
      xact(1'($urandom), a, $urandom, 4'($urandom), $urandom_range(0, 3), rd);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
